// File: rtl/muxn_pipe.sv
// Pipelined N:1 mux (N = 2**SEL_BITS) built as a 2:1 tree, registered every REG_EVERY levels.
// Optional build macro MUXN_PIPE_BUBBLE_ZERO_EN forces bubbles and flushed entries to zero data.

module muxn_pipe_stage #(
  parameter int WIDTH    = 8,
  parameter int SEL_BITS = 3,
  parameter int LO       = 0,
  parameter int HI       = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush_i,
  input  logic                                      stall_i,
  input  logic                                      vld_i,
  input  logic [(2**(SEL_BITS-LO))*WIDTH-1:0]       data_i,
  input  logic [SEL_BITS-LO-1:0]                    sel_i,
  output logic                                      vld_o,
  output logic [(2**(SEL_BITS-HI))*WIDTH-1:0]       data_o,
  output logic [((SEL_BITS-HI) > 0 ? (SEL_BITS-HI) : 1)-1:0] sel_o
);
  localparam int NIN  = 2**(SEL_BITS-LO);
  localparam int NOUT = 2**(SEL_BITS-HI);
  localparam int NLVL = HI - LO;
  localparam int SIN  = SEL_BITS - LO;
  localparam int SOUT = SEL_BITS - HI;
  localparam int SOW  = (SOUT > 0) ? SOUT : 1;

  logic [NIN*WIDTH-1:0]  lvl, nxt;
  logic [NOUT*WIDTH-1:0] tree;
  logic [SOW-1:0]        sel_rest;

  logic                  vld_q, vld_d;
  logic [NOUT*WIDTH-1:0] data_q, data_d;
  logic [SOW-1:0]        sel_q, sel_d;

  // Local sel bit l steers tree level LO+l; the surviving nodes pack into the low slots.
  always_comb begin
    lvl = data_i;
    nxt = '0;
    for (int l = 0; l < NLVL; l++) begin
      nxt = '0;
      for (int j = 0; j < NIN/2; j++) begin
        if (j < (NIN >> (l+1)))
          nxt[j*WIDTH +: WIDTH] = sel_i[l] ? lvl[(2*j+1)*WIDTH +: WIDTH]
                                           : lvl[(2*j)*WIDTH +: WIDTH];
      end
      lvl = nxt;
    end
    tree = lvl[NOUT*WIDTH-1:0];
  end

  if (SOUT > 0) begin : g_sel_rest
    assign sel_rest = sel_i[SIN-1:NLVL];
  end else begin : g_sel_done
    assign sel_rest = '0;
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    sel_d  = sel_q;
    if (flush_i) begin
      vld_d = 1'b0;
`ifdef MUXN_PIPE_BUBBLE_ZERO_EN
      data_d = '0;
      sel_d  = '0;
`endif
    end else if (!stall_i) begin
      vld_d = vld_i;
`ifdef MUXN_PIPE_BUBBLE_ZERO_EN
      data_d = vld_i ? tree : '0;
      sel_d  = vld_i ? sel_rest : '0;
`else
      data_d = tree;
      sel_d  = sel_rest;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign sel_o  = sel_q;
endmodule

module muxn_pipe #(
  parameter int  WIDTH     = 64,
  parameter int  SEL_BITS  = 5,
  parameter int  REG_EVERY = 1,
  parameter real DELAY     = 0.05
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [(2**SEL_BITS)*WIDTH-1:0]   in_i,
  input  logic [SEL_BITS-1:0]              sel_i,
  input  logic                             in_valid_i,
  input  logic                             stall_i,
  input  logic                             flush_i,
  output logic [WIDTH-1:0]                 out_o,
  output logic                             out_valid_o
);
  localparam int N   = 2**SEL_BITS;
  localparam int LAT = (SEL_BITS + REG_EVERY - 1) / REG_EVERY;
  // Gate delay only matters for the gate-level model; this RTL carries no delays.
  localparam real unused_delay_ns = DELAY;

  // Node buses between stages; each stage uses only the low slots it needs.
  logic [LAT:0][N*WIDTH-1:0]  dnode;
  logic [LAT:0][SEL_BITS-1:0] snode;
  logic [LAT:0]               vld_pipe;
  logic                       unused_nodes;

  assign dnode[0]    = in_i;
  assign snode[0]    = sel_i;
  assign vld_pipe[0] = in_valid_i;

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int LO   = s * REG_EVERY;
    localparam int HI   = (LO + REG_EVERY > SEL_BITS) ? SEL_BITS : LO + REG_EVERY;
    localparam int NIN  = N >> LO;
    localparam int NOUT = N >> HI;
    localparam int SOUT = SEL_BITS - HI;
    localparam int SOW  = (SOUT > 0) ? SOUT : 1;

    logic [NOUT*WIDTH-1:0] d_o;
    logic [SOW-1:0]        s_o;

    muxn_pipe_stage #(
      .WIDTH    (WIDTH),
      .SEL_BITS (SEL_BITS),
      .LO       (LO),
      .HI       (HI)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush_i),
      .stall_i (stall_i),
      .vld_i   (vld_pipe[s]),
      .data_i  (dnode[s][NIN*WIDTH-1:0]),
      .sel_i   (snode[s][SEL_BITS-LO-1:0]),
      .vld_o   (vld_pipe[s+1]),
      .data_o  (d_o),
      .sel_o   (s_o)
    );

    assign dnode[s+1] = {{((N-NOUT)*WIDTH){1'b0}}, d_o};

    if (SOUT > 0) begin : g_sel_fwd
      assign snode[s+1] = {{(SEL_BITS-SOUT){1'b0}}, s_o};
    end else begin : g_sel_end
      logic unused_sel;
      assign snode[s+1] = '0;
      assign unused_sel = ^s_o;
    end
  end

  assign unused_nodes = ^{dnode, snode};

  assign out_o       = dnode[LAT][WIDTH-1:0];
  assign out_valid_o = vld_pipe[LAT];
endmodule

// File: tb/tb_muxn_pipe.sv
// Scoreboard bench for muxn_pipe: three configurations share reset/stall/flush/in_valid,
// each compared against in[sel] delivered LAT unstalled cycles after sampling.

module tb_muxn_pipe;
  localparam int WA = 8,  SA = 3, NA = 8;
  localparam int WB = 64, SB = 5, NB = 32;
  localparam int LAT_A = 3, LAT_B = 1, LAT_C = 2;
`ifdef MUXN_PIPE_BUBBLE_ZERO_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif

  typedef struct { logic [63:0] d; int due; } exp_t;

  logic clk = 1'b0;
  logic reset, stall, flush, in_valid;
  logic [WA-1:0] a_in [NA];
  logic [WB-1:0] b_in [NB];
  logic [SA-1:0] sel_a;
  logic [SB-1:0] sel_b;
  logic [NA*WA-1:0] in_a;
  logic [NB*WB-1:0] in_b;
  logic [WA-1:0] out_a, out_c;
  logic [WB-1:0] out_b;
  logic ova, ovb, ovc;

  exp_t qa[$], qb[$], qc[$];
  int adv = 0, checks = 0, errors = 0;
  bit rst_seen = 1'b0, started = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    in_a = '0;
    for (int i = 0; i < NA; i++) in_a[i*WA +: WA] = a_in[i];
  end
  always_comb begin
    in_b = '0;
    for (int i = 0; i < NB; i++) in_b[i*WB +: WB] = b_in[i];
  end

  muxn_pipe #(.WIDTH(WA), .SEL_BITS(SA), .REG_EVERY(1), .DELAY(0.05)) u_a (
    .clk(clk), .reset(reset), .in_i(in_a), .sel_i(sel_a), .in_valid_i(in_valid),
    .stall_i(stall), .flush_i(flush), .out_o(out_a), .out_valid_o(ova));
  muxn_pipe #(.WIDTH(WB), .SEL_BITS(SB), .REG_EVERY(5), .DELAY(0.05)) u_b (
    .clk(clk), .reset(reset), .in_i(in_b), .sel_i(sel_b), .in_valid_i(in_valid),
    .stall_i(stall), .flush_i(flush), .out_o(out_b), .out_valid_o(ovb));
  muxn_pipe #(.WIDTH(WA), .SEL_BITS(SA), .REG_EVERY(2), .DELAY(0.05)) u_c (
    .clk(clk), .reset(reset), .in_i(in_a), .sel_i(sel_a), .in_valid_i(in_valid),
    .stall_i(stall), .flush_i(flush), .out_o(out_c), .out_valid_o(ovc));

  // Expected: valid iff the oldest outstanding entry is due now; data checked when valid,
  // right after reset, and on bubbles when bubble zeroing is built in.
  task automatic chk(input string nm, input logic v, input logic [63:0] o,
                     input bit ev, input logic [63:0] ed);
    checks++;
    if (v !== ev) begin
      errors++;
      $display("FAIL %s out_valid adv=%0d got %0b expected %0b", nm, adv, v, ev);
    end else if (ev || rst_seen || BZ) begin
      checks++;
      if (o !== (ev ? ed : 64'd0)) begin
        errors++;
        $display("FAIL %s out adv=%0d got %h expected %h", nm, adv, o, ev ? ed : 64'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("A", ova, {56'd0, out_a}, qa.size() > 0 && qa[0].due == adv,
          (qa.size() > 0) ? qa[0].d : 64'd0);
      chk("B", ovb, out_b, qb.size() > 0 && qb[0].due == adv,
          (qb.size() > 0) ? qb[0].d : 64'd0);
      chk("C", ovc, {56'd0, out_c}, qc.size() > 0 && qc[0].due == adv,
          (qc.size() > 0) ? qc[0].d : 64'd0);
    end
  end

  // One clock: model the edge from the inputs currently driven, then return at the negedge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      qa.delete(); qb.delete(); qc.delete();
      rst_seen = 1'b1;
      started  = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (flush) begin
        qa.delete(); qb.delete(); qc.delete();
      end else if (!stall) begin
        adv++;
        while (qa.size() > 0 && qa[0].due < adv) void'(qa.pop_front());
        while (qb.size() > 0 && qb[0].due < adv) void'(qb.pop_front());
        while (qc.size() > 0 && qc[0].due < adv) void'(qc.pop_front());
        if (in_valid) begin
          qa.push_back('{{56'd0, a_in[sel_a]}, adv + LAT_A - 1});
          qb.push_back('{b_in[sel_b], adv + LAT_B - 1});
          qc.push_back('{{56'd0, a_in[sel_a]}, adv + LAT_C - 1});
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < NA; i++) a_in[i] = 8'($urandom);
    for (int i = 0; i < NB; i++) b_in[i] = {$urandom, $urandom};
    sel_a = 3'($urandom);
    sel_b = 5'($urandom);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < NA; i++) a_in[i] = '0;
    for (int i = 0; i < NB; i++) b_in[i] = '0;
    sel_a = '0; sel_b = '0;
    @(negedge clk);
    step(); step();
    reset = 1'b0;

    // Back-to-back sweep A0..A7.
    for (int i = 0; i < NA; i++) a_in[i] = 8'(8'hA0 + i);
    for (int i = 0; i < NA; i++) begin
      in_valid = 1'b1; sel_a = 3'(i); sel_b = 5'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Same sweep with a 2-cycle stall after the third sample; inputs held meanwhile.
    for (int i = 0; i < NA; i++) begin
      in_valid = 1'b1; sel_a = 3'(i); sel_b = 5'($urandom);
      step();
      if (i == 2) begin
        stall = 1'b1;
        repeat (2) step();
        stall = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Full pipe, then flush and stall together.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; sel_a = 3'(7 - i); sel_b = 5'($urandom);
      step();
    end
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    repeat (4) step();

    // Reset mid-stream, then one new sample.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; sel_a = 3'(i + 2); sel_b = 5'($urandom);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b1; sel_a = 3'd5;
    step();
    in_valid = 1'b0;
    repeat (4) step();

    // Alternating bubbles.
    for (int i = 0; i < 16; i++) begin
      rand_data();
      in_valid = ~i[0];
      step();
    end

    // Random traffic with stall, flush and occasional reset; inputs held while stalled.
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 6) == 0);
      if (!stall) begin
        rand_data();
        in_valid = 1'($urandom);
      end
      flush = ($urandom_range(0, 18) == 0);
      reset = ($urandom_range(0, 96) == 0);
      step();
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
